// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder: GROUP-bit carry-lookahead adder/subtractor, one group resolved per stage,
// with unsigned saturation, signed-overflow flag and a valid/ready handshake with full backpressure.
module pipelined_cla_adder #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    input  logic             sat_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             sat
);
    localparam int STAGES = WIDTH / GROUP;
    localparam int L = STAGES - 1;

    logic [STAGES-1:0] v, en, up_v, c_r, o_r, sub_r, sen_r, c_n, o_n, sub_n, sen_n;
    logic [STAGES-1:0][WIDTH-1:0] a_r, b_r, s_r, a_n, b_n, s_n;

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        logic [WIDTH-1:0] a_i, b_i, s_i, s_o;
        logic c_i;
        logic [GROUP-1:0] p, g, m;
        logic [GROUP:0] c;
        // Operand B is stored already conditioned for subtraction.
        if (k == 0) begin : g_first
            assign a_i = a;
            assign b_i = sub ? ~b : b;
            assign s_i = '0;
            assign c_i = sub | cin;
            assign up_v[k] = in_valid;
            assign sub_n[k] = sub;
            assign sen_n[k] = sat_en;
        end else begin : g_next
            assign a_i = a_r[k-1];
            assign b_i = b_r[k-1];
            assign s_i = s_r[k-1];
            assign c_i = c_r[k-1];
            assign up_v[k] = v[k-1];
            assign sub_n[k] = sub_r[k-1];
            assign sen_n[k] = sen_r[k-1];
        end
        if (k == L) begin : g_last
            assign en[k] = !v[k] || out_ready;
        end else begin : g_fwd
            assign en[k] = !v[k] || en[k+1];
        end
        assign p = a_i[k*GROUP +: GROUP] ^ b_i[k*GROUP +: GROUP];
        assign g = a_i[k*GROUP +: GROUP] & b_i[k*GROUP +: GROUP];
        // Two-level lookahead: each carry ORs the generate terms propagated through the bits above them.
        always_comb begin
            c = '0;
            m = '0;
            c[0] = c_i;
            for (int i = 0; i < GROUP; i++) begin
                m = GROUP'((1 << (i + 1)) - 1);
                c[i+1] = c_i & (&(p | ~m));
                for (int j = 0; j <= i; j++)
                    c[i+1] = c[i+1] | (g[j] & (&(p | ~(m & ~GROUP'((1 << (j + 1)) - 1)))));
            end
        end
        always_comb begin
            s_o = s_i;
            s_o[k*GROUP +: GROUP] = p ^ c[GROUP-1:0];
        end
        assign s_n[k] = s_o;
        assign a_n[k] = a_i;
        assign b_n[k] = b_i;
        assign c_n[k] = c[GROUP];
        assign o_n[k] = c[GROUP] ^ c[GROUP-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v <= '0;
            a_r <= '0;
            b_r <= '0;
            s_r <= '0;
            c_r <= '0;
            o_r <= '0;
            sub_r <= '0;
            sen_r <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (en[k]) begin
                    v[k] <= up_v[k];
                    if (up_v[k]) begin
                        a_r[k] <= a_n[k];
                        b_r[k] <= b_n[k];
                        s_r[k] <= s_n[k];
                        c_r[k] <= c_n[k];
                        o_r[k] <= o_n[k];
                        sub_r[k] <= sub_n[k];
                        sen_r[k] <= sen_n[k];
                    end
                end
            end
        end
    end

    // Saturation is decoded from the held last-stage registers, so outputs stay stable under backpressure.
    assign in_ready = !rst && en[0];
    assign out_valid = v[L];
    assign cout = c_r[L];
    assign ovf = o_r[L];
    assign sat = sen_r[L] & (sub_r[L] ^ c_r[L]);
    assign sum = sat ? {WIDTH{~sub_r[L]}} : s_r[L];
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// tb_pipelined_cla_adder: directed and randomized checks of pipelined_cla_adder against an arithmetic model.
module tb_pipelined_cla_adder;
    localparam int W = 16;
    localparam int G = 4;
    localparam int S = W / G;

    logic clk = 0, rst = 1, in_valid = 0, cin = 0, sub = 0, sat_en = 0, out_ready = 1;
    logic [W-1:0] a = '0, b = '0, sum;
    logic in_ready, out_valid, cout, ovf, sat;
    logic lat_on = 0;
    logic [S-1:0] h = '0;
    logic [W+2:0] exp_q[$];
    int checks = 0, errors = 0;

    pipelined_cla_adder #(.WIDTH(W), .GROUP(G)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .sat_en(sat_en),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .sat(sat)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {sum, cout, ovf, sat} from plain integer arithmetic
    function automatic logic [W+2:0] model(input logic [W-1:0] x, y, input logic ci, s, e);
        logic [W:0] full;
        logic [W-1:0] yy, r;
        logic co, ov, st;
        yy = s ? ~y : y;
        full = {1'b0, x} + {1'b0, yy} + (W+1)'(s | ci);
        r = full[W-1:0];
        co = full[W];
        ov = (x[W-1] == yy[W-1]) && (r[W-1] != x[W-1]);
        st = e && (s ? !co : co);
        return {st ? {W{!s}} : r, co, ov, st};
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            h = '0;
        end else begin
            if (lat_on) check("latency_pattern", out_valid, h[S-1]);
            if (out_valid) begin
                if (exp_q.size() == 0) check("unexpected_out", out_valid, 1'b0);
                else begin
                    check("result", {sum, cout, ovf, sat}, exp_q[0]);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sub, sat_en));
            h = {h[S-2:0], in_valid && in_ready};
        end
    end

    task automatic send(input logic [W-1:0] ta, tb, input logic tc, ts, te);
        bit ok = 0;
        a = ta; b = tb; cin = tc; sub = ts; sat_en = te; in_valid = 1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1; break; end
        end
        if (!ok) check("send_timeout", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    task automatic run1(input string tag, input logic [W-1:0] ta, tb, input logic tc, ts, te,
                        input logic [W-1:0] es, input logic [2:0] ef);
        int n = 0;
        send(ta, tb, tc, ts, te);
        while (!out_valid && n < 20) begin @(negedge clk); n++; end
        check({tag, "_lat"}, n, S);
        check({tag, "_sum"}, sum, es);
        check({tag, "_flags"}, {cout, ovf, sat}, ef);
        @(posedge clk); #1;
    endtask

    task automatic drain();
        for (int n = 0; n < 50 && exp_q.size() != 0; n++) @(negedge clk);
        check("drain", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_flags", {cout, ovf, sat}, 0);
        rst = 0;
        #1;
        check("post_rst_in_ready", in_ready, 1);
        @(posedge clk); #1;
        // flags are {cout, ovf, sat}
        run1("add",       16'h00FF, 16'h0001, 0, 0, 0, 16'h0100, 3'b000);
        run1("wrap",      16'hFFFF, 16'h0001, 0, 0, 0, 16'h0000, 3'b100);
        run1("sat_add",   16'hFFFF, 16'h0001, 0, 0, 1, 16'hFFFF, 3'b101);
        run1("sub",       16'h0005, 16'h0007, 0, 1, 0, 16'hFFFE, 3'b000);
        run1("sat_sub",   16'h0005, 16'h0007, 0, 1, 1, 16'h0000, 3'b001);
        run1("ovf_add",   16'h7FFF, 16'h0001, 0, 0, 0, 16'h8000, 3'b010);
        run1("cin",       16'h0FFF, 16'h0000, 1, 0, 0, 16'h1000, 3'b000);
        run1("sub_cin",   16'h0010, 16'h0001, 1, 1, 1, 16'h000F, 3'b100);
        run1("ovf_sub",   16'h8000, 16'h0001, 0, 1, 0, 16'h7FFF, 3'b110);
        lat_on = 1;
        for (int i = 0; i < 20; i++) begin
            in_valid = (i % 2 == 0);
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom); sat_en = 1'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 0;
        repeat (6) @(posedge clk);
        #1;
        lat_on = 0;
        fork
            for (int i = 0; i < 8; i++) send(W'(i), 16'h0100, 0, 0, 0);
            begin
                repeat (5) @(posedge clk);
                #1 out_ready = 0;
                repeat (3) @(negedge clk);
                check("full_in_ready", in_ready, 0);
                check("full_out_valid", out_valid, 1);
                repeat (2) @(posedge clk);
                #1 out_ready = 1;
                #1 check("release_in_ready", in_ready, 1);
            end
        join
        drain();
        for (int i = 0; i < 300; i++) begin
            in_valid = $urandom_range(0, 3) != 0;
            a = ($urandom_range(0, 3) == 0) ? 16'hFFFF : W'($urandom);
            b = ($urandom_range(0, 3) == 0) ? 16'h0001 : W'($urandom);
            cin = 1'($urandom); sub = 1'($urandom); sat_en = 1'($urandom);
            out_ready = $urandom_range(0, 3) != 0;
            @(posedge clk); #1;
        end
        in_valid = 0;
        out_ready = 1;
        drain();
        send(16'h1111, 16'h2222, 0, 0, 0);
        send(16'h3333, 16'h4444, 0, 0, 0);
        send(16'h5555, 16'h6666, 0, 0, 0);
        rst = 1;
        @(posedge clk); #1;
        check("flush_out_valid", out_valid, 0);
        check("flush_sum", sum, 0);
        check("flush_flags", {cout, ovf, sat}, 0);
        check("flush_in_ready", in_ready, 0);
        rst = 0;
        #1 check("flush_rel_in_ready", in_ready, 1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("no_stale", out_valid, 0);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pipelined_cla_adder.md
Name: pipelined_cla_adder

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor for the image-filter datapath, e.g. kernel partial sums and pixel differences.
- Operands are split into GROUP-bit lookahead groups, with one group resolved per pipeline stage and the carry registered between stages.
- Adds subtract mode, unsigned saturation, signed-overflow detection and a valid/ready handshake with full backpressure.
- Sustains one result per clock.

Parameters:
- WIDTH, 16: operand and result width in bits. Must be a multiple of GROUP.
- GROUP, 4: bits resolved per stage by one lookahead group. STAGES = WIDTH/GROUP.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  a transaction is offered on the input side.
- in_ready  output  1  block can accept a transaction this cycle.
- a  input  WIDTH  operand A (unsigned or two's complement).
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; ignored when sub=1.
- sub  input  1  1: compute A-B (B inverted, carry-in forced to 1).
- sat_en  input  1  1: clamp the result to the unsigned range.
- out_valid  output  1  result is held on the outputs.
- out_ready  input  1  downstream accepts the result this cycle.
- sum  output  WIDTH  result (saturated when sat_en=1).
- cout  output  1  raw carry out of the MSB; for sub, 1 = no borrow.
- ovf  output  1  signed overflow of the unsaturated result.
- sat  output  1  saturation was applied to this result.

Behaviour:
- Reset (synchronous, active-high):
  - All stage valid bits clear; out_valid=0, sum=0, cout=0, ovf=0, sat=0.
  - in_ready=0 while rst=1; in_ready=1 the first cycle after rst falls.
  - A transaction or output presented during reset is discarded; no stale result ever appears after reset.
- Handshake:
  - Input transfer when in_valid && in_ready. Output transfer when out_valid && out_ready.
  - Output data and flags stay stable while out_valid=1 && out_ready=0.
- Pipeline:
  - STAGES register stages, with per-stage valid v[k].
  - Stage k advances when !v[k+1] || (k is last && out_ready) || stage k+1 advances; bubbles collapse.
  - in_ready = !v[0] || stage 0 advances (combinational from out_ready through the valid chain; no skid buffer).
- Stage k, group k = bits [k*GROUP +: GROUP]:
  - p = a^b', g = a&b', where b' = sub ? ~b : b.
  - Lookahead: c[i+1] = g[i] | p[i]&c[i], computed two-level from the registered carry.
  - s = p ^ c. The group carry-out is registered into stage k+1.
  - Unprocessed upper operand bits and the sub/sat_en flags travel with the transaction; processed sum bits accumulate in place.
  - Stage 0 carry-in = sub ? 1 : cin.
- Latency: a result accepted in cycle t is valid at t+STAGES with no stall (4 cycles at defaults). Throughput is 1 per cycle.
- Flags, evaluated at the last stage:
  - cout = final carry.
  - ovf = carry into MSB XOR carry out of MSB.
- Saturation (sat_en=1):
  - add && cout=1 → sum = all ones, sat=1.
  - sub && cout=0 (borrow) → sum = 0, sat=1.
  - Otherwise the raw sum is output with sat=0.
  - cout and ovf always reflect the unsaturated result.
  - sat_en=0 → sat=0 and the sum wraps modulo 2^WIDTH.
- Boundary conditions:
  - Pipeline full with out_ready=0 → in_ready=0 and no stage advances.
  - out_ready rising with the pipeline full → accept and emit in the same cycle (no lost slot).
  - Transactions stay in order; none is dropped or duplicated.
  - A carry that ripples across every group (e.g. 0xFFFF+1) resolves correctly through the registered stage carries.
  - in_valid falling mid-stream inserts bubbles; out_valid deasserts accordingly.
  - rst asserted mid-operation flushes all stages at that clock edge.

Test Plan (defaults WIDTH=16, GROUP=4):
- Basic add: a=0x00FF, b=0x0001, cin=0, sub=0, out_ready=1 → 4 cycles later sum=0x0100, cout=0, ovf=0, sat=0.
- Wrap vs saturate:
  - a=0xFFFF, b=0x0001, sat_en=0 → sum=0x0000, cout=1.
  - Same with sat_en=1 → sum=0xFFFF, sat=1, cout=1.
- Subtract and signed overflow:
  - a=0x0005, b=0x0007, sub=1 → sum=0xFFFE, cout=0; with sat_en=1 → sum=0x0000, sat=1.
  - a=0x7FFF, b=0x0001, add → sum=0x8000, ovf=1.
- Backpressure: 8 back-to-back inputs (a=i, b=0x0100, i=0..7) with out_ready=0 for cycles 5–9 → in_ready falls when 4 stages are full; outputs 0x0100..0x0107 in order, none lost.
- Carry-in and bubbles: cin=1, a=0x0FFF, b=0x0000 → sum=0x1000. Alternate in_valid 1/0 → out_valid pattern matches the input pattern delayed by 4 cycles.
- Reset mid-stream: 3 transactions in flight, rst=1 for 1 cycle → out_valid=0 and all outputs 0 the next cycle; no in-flight result ever emerges.
